mem_access_stage: RTL

// - Memory-access stage sitting directly upstream of the data RAM (32 x 32-bit, combinational read/write port).
// - Accepts one load/store/pass-through op per handshake from the execute stage and drives the RAM's Address/writeDta/WE/RE.
// - Captures the read data and presents a registered writeback result downstream with a valid/ready handshake.

---
 rtl/mem_access_stage_if.sv | 46 ++++
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: groups the three buses around the memory-access stage.
// Upstream op handshake (execute stage), the RAM port, and the downstream
// writeback handshake.
//   master : the memory-access stage itself (drives in_ready, RAM controls,
//            writeback result)
//   slave  : the surroundings (execute stage, data RAM, writeback stage)
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  // execute -> stage
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       alu_result;
  logic [DATA_W-1:0] store_data;
  logic              mem_read;
  logic              mem_write;
  logic [4:0]        rd_idx;
  logic              reg_write;
  // stage <-> data RAM
  logic [31:0]       Address;
  logic [DATA_W-1:0] writeDta;
  logic              WE;
  logic              RE;
  logic [DATA_W-1:0] Datoout;
  // stage -> writeback
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd_idx;
  logic              wb_reg_write;
  logic              out_err;

  modport master (
    input  in_valid, alu_result, store_data, mem_read, mem_write, rd_idx,
           reg_write, Datoout, out_ready,
    output in_ready, Address, writeDta, WE, RE, out_valid, wb_data,
           wb_rd_idx, wb_reg_write, out_err
  );

  modport slave (
    output in_valid, alu_result, store_data, mem_read, mem_write, rd_idx,
           reg_write, Datoout, out_ready,
    input  in_ready, Address, writeDta, WE, RE, out_valid, wb_data,
           wb_rd_idx, wb_reg_write, out_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage in front of a combinational
// data RAM. Takes one load/store/pass-through op per handshake, drives the RAM
// port for WAIT_CYCLES cycles, and presents a registered writeback result.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (reject word index >= DEPTH).
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no op held; ready to accept
// ACCESS | WE or RE asserted toward the RAM, counting down the wait cycles
// DONE   | result valid downstream; held until out_ready
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int BYTE_ADDR   = 0
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.master bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || DEPTH < 1) begin : g_bad_param
    $error("mem_access_stage: WAIT_CYCLES must be 1..15 and DEPTH >= 1");
  end

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state,        w_state_nxt;
  logic [3:0]        r_cnt,          w_cnt_nxt;
  logic              r_is_load,      w_is_load_nxt;
  logic [31:0]       r_addr,         w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,        w_wdata_nxt;
  logic              r_we,           w_we_nxt;
  logic              r_re,           w_re_nxt;
  logic              r_out_valid,    w_out_valid_nxt;
  logic [DATA_W-1:0] r_wb_data,      w_wb_data_nxt;
  logic [4:0]        r_wb_rd_idx,    w_wb_rd_idx_nxt;
  logic              r_wb_reg_write, w_wb_reg_write_nxt;
  logic              r_out_err,      w_out_err_nxt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_mem;
  logic              w_oob;
  logic [31:0]       w_word_idx;

  // Ready is combinational on out_ready so a consumed result and a new op can
  // share one edge; held low during reset so nothing is taken in.
  assign w_in_ready = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mem   = bus.mem_read || bus.mem_write;
  assign w_word_idx = (BYTE_ADDR != 0) ? {2'b00, bus.alu_result[31:2]} : bus.alu_result;

  // Out-of-range detection on the incoming op's word index.
  always_comb begin
`ifdef MEM_BOUNDS_CHECK_EN
    w_oob = w_is_mem && (w_word_idx >= 32'(DEPTH));
`else
    w_oob = 1'b0;
`endif
  end

  // Next-state and next-output decode; an accept overrides the per-state defaults.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_is_load_nxt      = r_is_load;
    w_addr_nxt         = r_addr;
    w_wdata_nxt        = r_wdata;
    w_we_nxt           = r_we;
    w_re_nxt           = r_re;
    w_out_valid_nxt    = r_out_valid;
    w_wb_data_nxt      = r_wb_data;
    w_wb_rd_idx_nxt    = r_wb_rd_idx;
    w_wb_reg_write_nxt = r_wb_reg_write;
    w_out_err_nxt      = r_out_err;

    case (r_state)
      IDLE: begin
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_we_nxt        = 1'b0;
          w_re_nxt        = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
          if (r_is_load) begin
            w_wb_data_nxt = bus.Datoout;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_err_nxt   = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_accept) begin
      w_wb_rd_idx_nxt = bus.rd_idx;
      w_out_err_nxt   = 1'b0;
      w_we_nxt        = 1'b0;
      w_re_nxt        = 1'b0;
      w_is_load_nxt   = 1'b0;
      if (w_is_mem && w_oob) begin
        w_state_nxt        = DONE;
        w_out_valid_nxt    = 1'b1;
        w_out_err_nxt      = 1'b1;
        w_wb_data_nxt      = '0;
        w_wb_reg_write_nxt = 1'b0;
      end else if (w_is_mem) begin
        // Store wins when both flags are set; a store never writes back.
        w_state_nxt        = ACCESS;
        w_out_valid_nxt    = 1'b0;
        w_cnt_nxt          = LP_CNT_INIT;
        w_addr_nxt         = w_word_idx;
        w_wdata_nxt        = bus.store_data;
        w_we_nxt           = bus.mem_write;
        w_re_nxt           = !bus.mem_write;
        w_is_load_nxt      = !bus.mem_write;
        w_wb_data_nxt      = DATA_W'(bus.alu_result);
        w_wb_reg_write_nxt = bus.mem_write ? 1'b0 : bus.reg_write;
      end else begin
        w_state_nxt        = DONE;
        w_out_valid_nxt    = 1'b1;
        w_wb_data_nxt      = DATA_W'(bus.alu_result);
        w_wb_reg_write_nxt = bus.reg_write;
      end
    end
  end

  // State and output registers; reset drops WE/RE at once, mid-access included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_is_load      <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_re           <= 1'b0;
      r_out_valid    <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd_idx    <= '0;
      r_wb_reg_write <= 1'b0;
      r_out_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_is_load      <= w_is_load_nxt;
      r_addr         <= w_addr_nxt;
      r_wdata        <= w_wdata_nxt;
      r_we           <= w_we_nxt;
      r_re           <= w_re_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_wb_data      <= w_wb_data_nxt;
      r_wb_rd_idx    <= w_wb_rd_idx_nxt;
      r_wb_reg_write <= w_wb_reg_write_nxt;
      r_out_err      <= w_out_err_nxt;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.Address      = r_addr;
  assign bus.writeDta     = r_wdata;
  assign bus.WE           = r_we;
  assign bus.RE           = r_re;
  assign bus.out_valid    = r_out_valid;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_rd_idx    = r_wb_rd_idx;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.out_err      = r_out_err;

endmodule
